pwm_breath_ctrl: RTL and testbench
==================================

# pwm_breath_ctrl

Sequencer that drives the control inputs of the team's PWM generator (`pwm_en`, `pwm_div`, `pwm_duty`) to produce a "breathing" envelope. Duty ramps linearly from a low level to a high level, holds, ramps back down, holds, and repeats for a programmed number of cycles or indefinitely. It sits directly upstream of the PWM generator, and its outputs connect one-to-one to that block's inputs.

## Interface
Parameters:
- `DIV`, 16'd1000: constant value driven on `pwm_div`. One PWM period is DIV×100 clk.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: level sampled each cycle; begins a sequence when in IDLE.
- `stop` in 1: aborts any sequence.
- `step_ticks` in 16: clk cycles per ±1 duty step; 0 is treated as 1.
- `hold_ticks` in 16: clk cycles in each hold state; 0 is treated as 1.
- `duty_lo` in 7: low duty in percent.
- `duty_hi` in 7: high duty in percent.
- `cycles` in 8: number of full breath cycles; 0 means infinite.
- `pwm_en` out 1: PWM enable.
- `pwm_div` out 16: PWM clock divider, always equal to DIV.
- `pwm_duty` out 7: current duty, 0–100.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a finite sequence completes.

## Operation
- States: IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO.
- Config latch:
  - In IDLE with `start`=1 and `stop`=0, latch all config inputs.
  - Clamp `lo`/`hi` to 100, then set `hi` = max(`lo`, `hi`).
  - Inputs are ignored while busy.
- IDLE → RAMP_UP: `pwm_duty`←`lo`, `pwm_en`←1, step counter and cycle counter cleared.
- RAMP_UP:
  - Step counter counts 0..S−1, where S = max(`step_ticks`, 1).
  - On the wrap cycle, `pwm_duty`←`pwm_duty`+1.
  - If the new value equals `hi`, go to HOLD_HI.
  - If `pwm_duty`==`hi` on entry (`lo`==`hi`), go to HOLD_HI on the next cycle with no change.
- HOLD_HI: stays for H = max(`hold_ticks`, 1) cycles, then goes to RAMP_DOWN.
- RAMP_DOWN: mirror of RAMP_UP (decrement toward `lo`), then goes to HOLD_LO.
- HOLD_LO: stays H cycles, then the breath cycle is complete and `cycle_cnt`+1.
  - If `cycles`≠0 and the new count equals `cycles`: go to IDLE, pulse `done`, `pwm_en`←0, `pwm_duty`←0.
  - Otherwise go to RAMP_UP with `pwm_duty` unchanged (already `lo`).
- Infinite mode: `cycle_cnt` saturates at 255; `done` is never asserted.
- `stop` (any state, highest priority after `rst`):
  - Next cycle: IDLE, `pwm_en`=0, `pwm_duty`=0, `busy`=0, no `done`.
  - If `stop` and `start` are both high in IDLE, the block stays in IDLE.
- Counters reset on every state entry. `pwm_duty` never leaves [`lo`, `hi`] while busy.

## Timing
- All outputs are registered.
- Reset values: `pwm_en`=0, `pwm_duty`=0, `busy`=0, `done`=0, `pwm_div`=DIV. State is IDLE and all counters are 0.
- `start` sampled at edge 0 → `busy`, `pwm_en` and `pwm_duty`=`lo` are visible after that edge. Latency is 1 cycle.
- Each ramp of D=`hi`−`lo`>0 steps lasts D×S cycles. When D=0 the ramp lasts 1 cycle. Each hold lasts H cycles.
- One breath cycle with D>0 lasts 2·D·S + 2·H cycles.
- `done` and the return to IDLE occur on the same edge at the end of the final HOLD_LO.
- A new `start` is accepted in the cycle after `busy` falls.
- `rst` mid-sequence returns the block to reset values on the next edge, regardless of other inputs.

## Structure
- Package `pwm_pkg`:
  - state enum `breath_state_t`
  - `DUTY_MAX` = 7'd100
  - `DUTY_W` = 7, `TICK_W` = 16
- Sub-module `pwm_tick_cnt`: a TICK_W terminal-count counter with ports `clr`, `en`, `limit` and a one-cycle `wrap` output; `limit` 0 is treated as 1.
  - Instantiated once and shared between step and hold timing, since only one is active per state.

## Test plan
- Reset and idle: `rst`=1 for 3 cycles, then idle for 10 cycles → `pwm_en`=0, `pwm_duty`=0, `busy`=0, `done`=0, `pwm_div`=1000 throughout.
- Single cycle, `lo`=10, `hi`=12, S=4, H=2, `cycles`=1, start at edge 0:
  - `pwm_duty` 10 @0, 11 @4, 12 @8, 11 @14, 10 @18
  - `done`=1 and `busy`=0 @20; `done` low @21
- Degenerate config, `lo`=50, `hi`=30, `step_ticks`=0, `hold_ticks`=0, `cycles`=2 → `hi` treated as 50, duty stays 50, each cycle lasts 4 clk, `done` @8.
- Clamp, `lo`=90, `hi`=120, S=1, H=1, `cycles`=1 → duty rises to exactly 100, never exceeds it, and returns to 90.
- Stop mid-ramp: `cycles`=0, `stop` pulsed during RAMP_DOWN → next cycle `pwm_en`=0, `pwm_duty`=0, `busy`=0, no `done`. `start`+`stop` asserted together in IDLE → remains IDLE.
- Infinite run: `cycles`=0 for 300 cycles of lo=0, hi=1, S=1, H=1 → still busy, `done` never asserted. `start` pulses while busy leave the config unchanged.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the breathing-envelope PWM sequencer.
package pwm_pkg;

  localparam int DUTY_W = 7;
  localparam int TICK_W = 16;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } breath_state_t;

  // Duty requests above 100 percent are pulled back to 100.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

endpackage

// File: rtl/pwm_tick_cnt.sv
// Terminal-count tick counter shared by the ramp step and hold timers.
// wrap is asserted on the last cycle of each limit-long period; a limit of 0
// behaves as 1 so the counter wraps every enabled cycle.
module pwm_tick_cnt
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [TICK_W-1:0] limit,
  output logic              wrap
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] last;

  // wrap must not depend on clr: the owner derives clr from wrap.
  assign last = (limit == '0) ? '0 : (limit - 16'd1);
  assign wrap = en && (cnt_q == last);

  // Count up while enabled, fold back to zero on wrap or explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (wrap) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-envelope sequencer feeding the PWM generator's en/div/duty inputs.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | outputs parked (en=0, duty=0); waits for start
// RAMP_UP   | duty += 1 every S clk until it reaches hi
// HOLD_HI   | duty held at hi for H clk
// RAMP_DOWN | duty -= 1 every S clk until it reaches lo
// HOLD_LO   | duty held at lo for H clk; ends one breath cycle
module pwm_breath_ctrl
  import pwm_pkg::*;
#(
  parameter logic [15:0] DIV = 16'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] step_ticks,
  input  logic [TICK_W-1:0] hold_ticks,
  input  logic [DUTY_W-1:0] duty_lo,
  input  logic [DUTY_W-1:0] duty_hi,
  input  logic [7:0]        cycles,
  output logic              pwm_en,
  output logic [15:0]       pwm_div,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              busy,
  output logic              done
);

  breath_state_t state_q, state_d;

  logic [DUTY_W-1:0] lo_q, hi_q;
  logic [TICK_W-1:0] step_q, hold_q;
  logic [7:0]        cycles_q;
  logic [7:0]        cycle_cnt_q, cycle_cnt_d;

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic [DUTY_W-1:0] lo_in, hi_clamped, hi_in;
  logic [DUTY_W-1:0] duty_inc, duty_dec;
  logic [7:0]        cnt_next;

  logic              tick_clr, tick_en, tick_wrap;
  logic [TICK_W-1:0] tick_limit;

  // Config is only captured on an accepted start; hi never sits below lo.
  assign accept     = (state_q == IDLE) && start && !stop;
  assign lo_in      = clamp_duty(duty_lo);
  assign hi_clamped = clamp_duty(duty_hi);
  assign hi_in      = (hi_clamped < lo_in) ? lo_in : hi_clamped;

  assign duty_inc = duty_q + 7'd1;
  assign duty_dec = duty_q - 7'd1;
  assign cnt_next = (cycle_cnt_q == 8'hFF) ? 8'hFF : (cycle_cnt_q + 8'd1);

  // One timer serves both ramps and holds; it restarts on every state change.
  assign tick_en    = (state_q != IDLE);
  assign tick_clr   = (state_d != state_q);
  assign tick_limit = ((state_q == RAMP_UP) || (state_q == RAMP_DOWN)) ? step_q : hold_q;

  pwm_tick_cnt u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr),
    .en    (tick_en),
    .limit (tick_limit),
    .wrap  (tick_wrap)
  );

  // Latch the sequence configuration when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      cycles_q <= '0;
    end else if (accept) begin
      lo_q     <= lo_in;
      hi_q     <= hi_in;
      step_q   <= step_ticks;
      hold_q   <= hold_ticks;
      cycles_q <= cycles;
    end
  end

  // Next-state and next-output decode; stop overrides everything but rst.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    en_d        = en_q;
    done_d      = 1'b0;
    cycle_cnt_d = cycle_cnt_q;

    if (stop) begin
      state_d = IDLE;
      duty_d  = '0;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RAMP_UP;
            duty_d      = lo_in;
            en_d        = 1'b1;
            cycle_cnt_d = '0;
          end
        end

        RAMP_UP: begin
          if (duty_q == hi_q) begin
            state_d = HOLD_HI;
          end else if (tick_wrap) begin
            duty_d = duty_inc;
            if (duty_inc == hi_q) begin
              state_d = HOLD_HI;
            end
          end
        end

        HOLD_HI: begin
          if (tick_wrap) begin
            state_d = RAMP_DOWN;
          end
        end

        RAMP_DOWN: begin
          if (duty_q == lo_q) begin
            state_d = HOLD_LO;
          end else if (tick_wrap) begin
            duty_d = duty_dec;
            if (duty_dec == lo_q) begin
              state_d = HOLD_LO;
            end
          end
        end

        HOLD_LO: begin
          if (tick_wrap) begin
            cycle_cnt_d = cnt_next;
            if ((cycles_q != 8'd0) && (cnt_next == cycles_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              en_d    = 1'b0;
              duty_d  = '0;
            end else begin
              state_d = RAMP_UP;
            end
          end
        end

        default: begin
          state_d = IDLE;
          duty_d  = '0;
          en_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign pwm_en   = en_q;
  assign pwm_div  = DIV;
  assign pwm_duty = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Self-checking bench for pwm_breath_ctrl: an envelope model computed from
// elapsed time since start, checked every cycle, plus literal spot checks.
module tb_pwm_breath_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] step_ticks;
  logic [15:0] hold_ticks;
  logic [6:0]  duty_lo;
  logic [6:0]  duty_hi;
  logic [7:0]  cycles;
  logic        pwm_en;
  logic [15:0] pwm_div;
  logic [6:0]  pwm_duty;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int e     = 0;

  // Model state: whether a sequence runs, cycles elapsed since start edge.
  bit m_act  = 1'b0;
  bit m_done = 1'b0;
  int m_k    = 0;
  int m_lo, m_hi, m_s, m_h, m_cyc;
  int lo_v, hi_v;

  int peak      = 0;
  bit done_seen = 1'b0;

  pwm_breath_ctrl #(.DIV(16'd1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_ticks (step_ticks),
    .hold_ticks (hold_ticks),
    .duty_lo    (duty_lo),
    .duty_hi    (duty_hi),
    .cycles     (cycles),
    .pwm_en     (pwm_en),
    .pwm_div    (pwm_div),
    .pwm_duty   (pwm_duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int ramp_len(input int lo, input int hi, input int s);
    return (hi > lo) ? (hi - lo) * s : 1;
  endfunction

  function automatic int period_of(input int lo, input int hi, input int s, input int h);
    return 2 * ramp_len(lo, hi, s) + 2 * h;
  endfunction

  // Duty k cycles after the start edge, from the envelope shape alone.
  function automatic int duty_at(input int k, input int lo, input int hi, input int s, input int h);
    int r, t;
    r = ramp_len(lo, hi, s);
    t = k % period_of(lo, hi, s, h);
    if (t < r)         return (hi > lo) ? lo + t / s : lo;
    if (t < r + h)     return hi;
    if (t < 2 * r + h) return (hi > lo) ? hi - (t - r - h) / s : hi;
    return lo;
  endfunction

  // Model advance at each clock edge from the inputs seen at that edge.
  always @(posedge clk) begin
    if (rst || stop) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
    end else if (!m_act) begin
      m_done <= 1'b0;
      if (start) begin
        lo_v = (duty_lo > 7'd100) ? 100 : int'(duty_lo);
        hi_v = (duty_hi > 7'd100) ? 100 : int'(duty_hi);
        if (hi_v < lo_v) hi_v = lo_v;
        m_lo  <= lo_v;
        m_hi  <= hi_v;
        m_s   <= (step_ticks == 16'd0) ? 1 : int'(step_ticks);
        m_h   <= (hold_ticks == 16'd0) ? 1 : int'(hold_ticks);
        m_cyc <= int'(cycles);
        m_act <= 1'b1;
        m_k   <= 0;
      end
    end else begin
      if ((m_cyc != 0) && (m_k + 1 == m_cyc * period_of(m_lo, m_hi, m_s, m_h))) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_k    <= m_k + 1;
        m_done <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("pwm_en", int'(pwm_en), int'(m_act));
    chk("pwm_duty", int'(pwm_duty), m_act ? duty_at(m_k, m_lo, m_hi, m_s, m_h) : 0);
    chk("busy", int'(busy), int'(m_act));
    chk("done", int'(done), int'(m_done));
    chk("pwm_div", int'(pwm_div), 1000);
    if (busy && int'(pwm_duty) > peak) peak = int'(pwm_duty);
    if (done) done_seen = 1'b1;
  end

  task automatic goto_edge(input int n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    e = 0;
    #1;
    start = 1'b0;
  endtask

  task automatic cfg(input int lo, input int hi, input int s, input int h, input int c);
    duty_lo    = 7'(lo);
    duty_hi    = 7'(hi);
    step_ticks = 16'(s);
    hold_ticks = 16'(h);
    cycles     = 8'(c);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_duty", int'(pwm_duty), 0);

    // Single breath: lo=10 hi=12 S=4 H=2.
    @(negedge clk);
    cfg(10, 12, 4, 2, 1);
    launch();
    chk("single_d0", int'(pwm_duty), 10);
    chk("single_en0", int'(pwm_en), 1);
    goto_edge(4);  chk("single_d4", int'(pwm_duty), 11);
    goto_edge(8);  chk("single_d8", int'(pwm_duty), 12);
    goto_edge(14); chk("single_d14", int'(pwm_duty), 11);
    goto_edge(18); chk("single_d18", int'(pwm_duty), 10);
    goto_edge(20);
    chk("single_done20", int'(done), 1);
    chk("single_busy20", int'(busy), 0);

    // Restart right after busy falls with a degenerate config.
    @(negedge clk);
    cfg(50, 30, 0, 0, 2);
    start = 1'b1;
    goto_edge(21);
    start = 1'b0;
    chk("single_done21", int'(done), 0);
    chk("degen_busy21", int'(busy), 1);
    chk("degen_d21", int'(pwm_duty), 50);
    goto_edge(25); chk("degen_d25", int'(pwm_duty), 50);
    goto_edge(28); chk("degen_busy28", int'(busy), 1);
    goto_edge(29); chk("degen_done29", int'(done), 1);

    // Clamp: hi 120 behaves as 100.
    @(negedge clk);
    cfg(90, 120, 1, 1, 1);
    peak = 0;
    launch();
    chk("clamp_d0", int'(pwm_duty), 90);
    goto_edge(10); chk("clamp_d10", int'(pwm_duty), 100);
    goto_edge(21); chk("clamp_d21", int'(pwm_duty), 90);
    goto_edge(22); chk("clamp_done22", int'(done), 1);
    chk("clamp_peak", peak, 100);

    // Stop during RAMP_DOWN of an infinite sequence.
    @(negedge clk);
    cfg(10, 20, 2, 1, 0);
    done_seen = 1'b0;
    launch();
    goto_edge(25); chk("stop_d25", int'(pwm_duty), 18);
    @(negedge clk);
    stop = 1'b1;
    goto_edge(26);
    stop = 1'b0;
    chk("stop_en", int'(pwm_en), 0);
    chk("stop_duty", int'(pwm_duty), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_nodone", int'(done_seen), 0);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    goto_edge(27);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);

    // Infinite run of lo=0 hi=1 S=1 H=1 for 300 breaths.
    @(negedge clk);
    cfg(0, 1, 1, 1, 0);
    done_seen = 1'b0;
    launch();
    goto_edge(600);
    @(negedge clk);
    cfg(40, 60, 3, 3, 1);
    start = 1'b1;
    goto_edge(601);
    start = 1'b0;
    goto_edge(1200);
    chk("inf_busy", int'(busy), 1);
    chk("inf_duty", int'(pwm_duty), 0);
    chk("inf_nodone", int'(done_seen), 0);
    @(negedge clk);
    stop = 1'b1;
    goto_edge(1201);
    stop = 1'b0;
    chk("inf_stop_busy", int'(busy), 0);

    // Reset in mid-sequence wins over a simultaneous start.
    @(negedge clk);
    cfg(5, 9, 2, 2, 3);
    launch();
    goto_edge(5);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    goto_edge(6);
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(pwm_en), 0);
    chk("rst_duty", int'(pwm_duty), 0);
    goto_edge(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
